// File: rtl/rv32_multicycle_controller_if.sv
// rv32_multicycle_controller_if: instruction-memory fetch handshake.
//   req   - fetch request, held by the controller until ack
//   ack   - fetch data valid this cycle
//   rdata - 32-bit instruction word
interface rv32_multicycle_controller_if;
  logic        req;
  logic        ack;
  logic [31:0] rdata;
  modport master (output req, input ack, rdata);
  modport slave  (input req, output ack, rdata);
endinterface

// File: rtl/rv32_multicycle_controller.sv
// rv32_multicycle_controller: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for RV32I ALU ops.
//   clk, rst_n      - clock (rising edge), asynchronous active-low reset
//   i_run           - level enable for instruction issue
//   imem            - fetch handshake (master side)
//   o_rs1/o_rs2/o_rd/o_imm - register and immediate fields of the IR
//   o_alu_op, o_use_imm    - ALU control (valid in DECODE, EXECUTE, WRITEBACK)
//   o_reg_write, o_pc_write - single-cycle WRITEBACK strobes
//   o_state, o_halted, o_illegal, o_fault, o_retired - status
module rv32_multicycle_controller #(
  parameter int FETCH_TIMEOUT = 15,
  parameter bit HALT_ON_ZERO  = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_run,
  rv32_multicycle_controller_if.master        imem,
  output logic [4:0]                          o_rs1,
  output logic [4:0]                          o_rs2,
  output logic [4:0]                          o_rd,
  output logic [11:0]                         o_imm,
  output logic [2:0]                          o_alu_op,
  output logic                                o_use_imm,
  output logic                                o_reg_write,
  output logic                                o_pc_write,
  output logic [2:0]                          o_state,
  output logic                                o_halted,
  output logic                                o_illegal,
  output logic                                o_fault,
  output logic [31:0]                         o_retired
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT} state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLT} alu_op_t;
  state_t      r_state, w_next;
  alu_op_t     w_dec_op;
  logic [31:0] r_ir, r_wait, r_retired;
  logic        r_illegal, r_fault;
  logic        w_set_ill, w_set_fault, w_timeout, w_active;
  logic        w_r, w_i, w_f3_ok, w_legal;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  assign w_f3    = r_ir[14:12];
  assign w_f7    = r_ir[31:25];
  assign w_r     = r_ir[6:0] == 7'b0110011;
  assign w_i     = r_ir[6:0] == 7'b0010011;
  assign w_f3_ok = w_f3 != 3'b011;
  // funct3 x01 are the shifts: their upper bits must be zero, which rules out SRA/SRAI
  assign w_legal = (w_r && w_f3_ok && (w_f7 == 7'b0 || (w_f7 == 7'b0100000 && w_f3 == 3'b000))) ||
                   (w_i && w_f3_ok && (w_f3[1:0] != 2'b01 || w_f7 == 7'b0));
  // r_wait counts completed FETCH cycles without ack, so the T-th such cycle times out
  assign w_timeout = (FETCH_TIMEOUT != 0) && (r_wait == 32'(FETCH_TIMEOUT - 1));
  assign w_active  = r_state == S_DECODE || r_state == S_EXECUTE || r_state == S_WRITEBACK;
  always_comb begin
    w_dec_op = ALU_ADD;
    case (w_f3)
      3'b000:  w_dec_op = (w_r && w_f7[5]) ? ALU_SUB : ALU_ADD;
      3'b111:  w_dec_op = ALU_AND;
      3'b110:  w_dec_op = ALU_OR;
      3'b100:  w_dec_op = ALU_XOR;
      3'b001:  w_dec_op = ALU_SLL;
      3'b101:  w_dec_op = ALU_SRL;
      3'b010:  w_dec_op = ALU_SLT;
      default: w_dec_op = ALU_ADD;
    endcase
  end
  always_comb begin
    w_next      = r_state;
    w_set_ill   = 1'b0;
    w_set_fault = 1'b0;
    case (r_state)
      S_IDLE:      w_next = i_run ? S_FETCH : S_IDLE;
      S_FETCH: begin
        if (imem.ack) w_next = S_DECODE;
        else if (w_timeout) begin
          w_next      = S_HALT;
          w_set_fault = 1'b1;
        end
      end
      S_DECODE: begin
        if (HALT_ON_ZERO && r_ir == 32'b0) w_next = S_HALT;
        else if (!w_legal) begin
          w_next    = S_HALT;
          w_set_ill = 1'b1;
        end else w_next = S_EXECUTE;
      end
      S_EXECUTE:   w_next = S_WRITEBACK;
      S_WRITEBACK: w_next = i_run ? S_FETCH : S_IDLE;
      default:     w_next = S_HALT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ir      <= '0;
      r_wait    <= '0;
      r_retired <= '0;
      r_illegal <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_ir      <= (r_state == S_FETCH && imem.ack) ? imem.rdata : r_ir;
      r_wait    <= (r_state == S_FETCH && !imem.ack) ? r_wait + 32'd1 : 32'd0;
      r_retired <= (r_state == S_WRITEBACK) ? r_retired + 32'd1 : r_retired;
      r_illegal <= r_illegal | w_set_ill;
      r_fault   <= r_fault | w_set_fault;
    end
  end
  assign imem.req    = r_state == S_FETCH;
  assign o_rs1       = r_ir[19:15];
  assign o_rs2       = r_ir[24:20];
  assign o_rd        = r_ir[11:7];
  assign o_imm       = r_ir[31:20];
  assign o_alu_op    = w_active ? w_dec_op : ALU_ADD;
  assign o_use_imm   = w_active && w_i;
  assign o_pc_write  = r_state == S_WRITEBACK;
  assign o_reg_write = r_state == S_WRITEBACK && r_ir[11:7] != 5'd0;
  assign o_state     = r_state;
  assign o_halted    = r_state == S_HALT;
  assign o_illegal   = r_illegal;
  assign o_fault     = r_fault;
  assign o_retired   = r_retired;
endmodule

// File: tb/tb_rv32_multicycle_controller.sv
// tb_rv32_multicycle_controller: directed checks of the multi-cycle controller.
module tb_rv32_multicycle_controller;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [4:0]  rs1, rs2, rd;
  logic [11:0] imm;
  logic [2:0]  alu_op, state;
  logic        use_imm, reg_write, pc_write, halted, illegal, fault;
  logic [31:0] retired;
  int          n_cmp = 0;
  int          n_err = 0;
  rv32_multicycle_controller_if imem ();
  rv32_multicycle_controller #(.FETCH_TIMEOUT(15), .HALT_ON_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .i_run(run), .imem(imem.master),
    .o_rs1(rs1), .o_rs2(rs2), .o_rd(rd), .o_imm(imm), .o_alu_op(alu_op), .o_use_imm(use_imm),
    .o_reg_write(reg_write), .o_pc_write(pc_write), .o_state(state), .o_halted(halted),
    .o_illegal(illegal), .o_fault(fault), .o_retired(retired)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    run = 1'b0;
    imem.ack = 1'b0;
    imem.rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic halt_case(input string tag, input logic [31:0] word, input logic exp_ill);
    do_reset();
    run = 1'b1;
    imem.ack = 1'b1;
    imem.rdata = word;
    step();
    step();
    imem.ack = 1'b0;
    step();
    check({tag, "_halted"}, 32'(halted), 32'd1);
    check({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
    check({tag, "_retired"}, retired, 32'd0);
    step();
    check({tag, "_absorb"}, 32'(state), 32'd5);
  endtask
  initial begin
    imem.ack = 1'b0;
    imem.rdata = '0;
    // reset state
    step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_strobes", {28'd0, imem.req, reg_write, pc_write, halted}, 32'd0);
    check("rst_sticky", {30'd0, illegal, fault}, 32'd0);
    check("rst_retired", retired, 32'd0);
    // add x7,x6,x5 with immediate ack
    run = 1'b1;
    imem.ack = 1'b1;
    imem.rdata = 32'h005303b3;
    rst_n = 1'b1;
    step();
    check("t1_fetch", 32'(state), 32'd1);
    check("t1_req", 32'(imem.req), 32'd1);
    step();
    imem.ack = 1'b0;
    check("t1_decode", 32'(state), 32'd2);
    step();
    check("t1_exec", 32'(state), 32'd3);
    check("t1_alu", {alu_op, 3'd0, use_imm}, {3'd0, 3'd0, 1'b0});
    check("t1_regs", {rs1, rs2, rd}, {5'd6, 5'd5, 5'd7});
    step();
    check("t1_wb", {state, reg_write, pc_write}, {3'd4, 1'b1, 1'b1});
    check("t1_ret_wb", retired, 32'd0);
    step();
    check("t1_retired", retired, 32'd1);
    check("t1_refetch", 32'(state), 32'd1);
    // sub then addi back to back
    do_reset();
    run = 1'b1;
    imem.ack = 1'b1;
    imem.rdata = 32'h40848533;
    step();
    step();
    step();
    check("t2_sub", {alu_op, use_imm}, {3'd1, 1'b0});
    check("t2_sub_rd", 32'(rd), 32'd10);
    imem.rdata = 32'h00160693;
    step();
    step();
    step();
    step();
    check("t2_addi", {alu_op, use_imm}, {3'd0, 1'b1});
    check("t2_addi_f", {imm, 3'd0, rd}, {12'h001, 3'd0, 5'd13});
    step();
    step();
    check("t2_retired", retired, 32'd2);
    // ack delayed three cycles
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_req_held", {imem.req, state}, {1'b1, 3'd1});
      if (i == 3) begin
        imem.ack = 1'b1;
        imem.rdata = 32'h00160693;
      end
    end
    step();
    imem.ack = 1'b0;
    check("t3_decode", {imem.req, state}, {1'b0, 3'd2});
    check("t3_ir", {imm, 3'd0, rd}, {12'h001, 3'd0, 5'd13});
    // fetch timeout after exactly 15 cycles
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      check("t4_fetching", 32'(state), 32'd1);
    end
    step();
    check("t4_halt", {state, halted, fault, imem.req}, {3'd5, 1'b1, 1'b1, 1'b0});
    check("t4_illegal", 32'(illegal), 32'd0);
    // ack on the 15th fetch cycle wins over the timeout
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 15; i++) step();
    imem.ack = 1'b1;
    imem.rdata = 32'h005303b3;
    step();
    imem.ack = 1'b0;
    check("t5_ack_wins", {state, fault}, {3'd2, 1'b0});
    // halting decode cases
    halt_case("zero", 32'h00000000, 1'b0);
    halt_case("branch", 32'h00000063, 1'b1);
    halt_case("srai", 32'h4000d013, 1'b1);
    halt_case("sltu", 32'h00003033, 1'b1);
    // rd=x0 suppresses reg_write; run dropped in EXECUTE completes then idles
    do_reset();
    run = 1'b1;
    imem.ack = 1'b1;
    imem.rdata = 32'h00208033;
    step();
    step();
    imem.ack = 1'b0;
    step();
    run = 1'b0;
    step();
    check("t6_wb", {state, reg_write, pc_write}, {3'd4, 1'b0, 1'b1});
    step();
    check("t6_idle", {state, imem.req}, {3'd0, 1'b0});
    check("t6_retired", retired, 32'd1);
    // asynchronous reset in the middle of EXECUTE
    do_reset();
    run = 1'b1;
    imem.ack = 1'b1;
    imem.rdata = 32'h40848533;
    step();
    step();
    imem.ack = 1'b0;
    step();
    check("t7_exec", {state, alu_op}, {3'd3, 3'd1});
    #2 rst_n = 1'b0;
    #1;
    check("t7_async", {state, alu_op, reg_write, pc_write, imem.req}, {3'd0, 3'd0, 1'b0, 1'b0, 1'b0});
    step();
    rst_n = 1'b1;
    step();
    check("t7_resume", 32'(state), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
